// File: rtl/jtag_pin_frontend_if.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pin_frontend_if
//  Description : Pin-side and event-side signal bundle for jtag_pin_frontend.
//                The master side drives the raw JTAG pins and consumes the
//                clean events; the slave side is the front-end itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jtag_pin_frontend_if;
  // Raw, asynchronous JTAG pins.
  logic       jtag_clk;
  logic       jtag_tms;
  logic       jtag_tdi;

  // Clean sys_clk-domain events.
  logic       tck_rise;
  logic       tck_fall;
  logic       tms_smp;
  logic       tdi_smp;
  logic       tck_level;
  logic       tap_reset;
  logic       tck_idle;
  logic [7:0] glitch_cnt;

  modport master (
    output jtag_clk, jtag_tms, jtag_tdi,
    input  tck_rise, tck_fall, tms_smp, tdi_smp,
           tck_level, tap_reset, tck_idle, glitch_cnt
  );

  modport slave (
    input  jtag_clk, jtag_tms, jtag_tdi,
    output tck_rise, tck_fall, tms_smp, tdi_smp,
           tck_level, tap_reset, tck_idle, glitch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/jtag_pin_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_pin_frontend
//  Description : Synchronizes the asynchronous TCK/TMS/TDI pins into sys_clk,
//                glitch-filters TCK and emits one-cycle rise/fall strobes with
//                TMS/TDI captured at the rising edge. Also flags the forced
//                TAP reset sequence (consecutive TMS-high rises) and TCK
//                inactivity, and counts rejected TCK pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_pin_frontend #(
  parameter int SYNC_STAGES     = 2,         // 2..4
  parameter int FILTER_LEN      = 16,        // >= 2
  parameter int IDLE_TIMEOUT    = 27000000,  // fits in 25 bits
  parameter int RESET_TMS_COUNT = 5
) (
  input  wire                 sys_clk,
  input  wire                 sys_rst_n,
  jtag_pin_frontend_if.slave  pins
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_fcnt_w = $clog2(FILTER_LEN);
  localparam int c_rcnt_w = $clog2(RESET_TMS_COUNT + 1);
  localparam int c_idle_w = 25;

  localparam logic [c_fcnt_w-1:0] c_fcnt_one  = c_fcnt_w'(1);
  localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FILTER_LEN - 1);
  localparam logic [c_rcnt_w-1:0] c_rcnt_max  = c_rcnt_w'(RESET_TMS_COUNT);
  localparam logic [c_rcnt_w-1:0] c_rcnt_arm  = c_rcnt_w'(RESET_TMS_COUNT - 1);
  localparam logic [c_idle_w-1:0] c_idle_max  = c_idle_w'(IDLE_TIMEOUT);
  localparam logic [7:0]          c_glitch_max = 8'hFF;

  // --------------------------------------------------------------------------
  // Filter state encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_tck_sync;
  logic [SYNC_STAGES-1:0] r_tms_sync;
  logic [SYNC_STAGES-1:0] r_tdi_sync;
  logic                   w_tck_s;
  logic                   w_tms_s;
  logic                   w_tdi_s;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [c_fcnt_w-1:0]    r_fcnt;
  logic [c_fcnt_w-1:0]    w_fcnt_next;
  logic                   w_capture;
  logic                   w_accept_rise;
  logic                   w_accept_fall;
  logic                   w_accept_any;
  logic                   w_glitch;

  logic                   r_cand_tms;
  logic                   r_cand_tdi;
  logic                   r_tck_rise;
  logic                   r_tck_fall;
  logic                   r_tms_smp;
  logic                   r_tdi_smp;
  logic                   r_tck_level;
  logic [7:0]             r_glitch_cnt;

  logic [c_rcnt_w-1:0]    r_rcnt;
  logic                   r_tap_reset;

  logic [c_idle_w-1:0]    r_idle_cnt;
  logic [c_idle_w-1:0]    w_idle_cnt_next;
  logic                   r_tck_idle;

  // --------------------------------------------------------------------------
  // Pin synchronizers
  // --------------------------------------------------------------------------
  // Shift every raw pin through its own SYNC_STAGES-deep flop chain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], pins.jtag_clk};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], pins.jtag_tms};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], pins.jtag_tdi};
    end
  end

  assign w_tck_s = r_tck_sync[SYNC_STAGES-1];
  assign w_tms_s = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi_s = r_tdi_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // TCK filter FSM
  // --------------------------------------------------------------------------
  // State and hold counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_LOW;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
    end
  end

  // A new level must hold FILTER_LEN samples (counting the first one) before
  // the edge is accepted; reverting earlier counts as a rejected pulse.
  always_comb begin
    w_state_next  = r_state;
    w_fcnt_next   = r_fcnt;
    w_capture     = 1'b0;
    w_accept_rise = 1'b0;
    w_accept_fall = 1'b0;
    w_glitch      = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (w_tck_s) begin
          w_state_next = ST_RISE_PEND;
          w_fcnt_next  = c_fcnt_one;
          w_capture    = 1'b1;
        end
      end
      ST_RISE_PEND: begin
        if (!w_tck_s) begin
          w_state_next = ST_LOW;
          w_glitch     = 1'b1;
        end else if (r_fcnt == c_fcnt_last) begin
          w_state_next  = ST_HIGH;
          w_accept_rise = 1'b1;
        end else begin
          w_fcnt_next = r_fcnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!w_tck_s) begin
          w_state_next = ST_FALL_PEND;
          w_fcnt_next  = c_fcnt_one;
        end
      end
      ST_FALL_PEND: begin
        if (w_tck_s) begin
          w_state_next = ST_HIGH;
          w_glitch     = 1'b1;
        end else if (r_fcnt == c_fcnt_last) begin
          w_state_next  = ST_LOW;
          w_accept_fall = 1'b1;
        end else begin
          w_fcnt_next = r_fcnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_LOW;
      end
    endcase
  end

  assign w_accept_any = w_accept_rise | w_accept_fall;

  // --------------------------------------------------------------------------
  // Edge strobes, sampled data and level
  // --------------------------------------------------------------------------
  // TMS/TDI are latched as candidates at the first high TCK sample, so the
  // value reported is the one present at the pin edge, not after filtering.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cand_tms  <= 1'b0;
      r_cand_tdi  <= 1'b0;
      r_tck_rise  <= 1'b0;
      r_tck_fall  <= 1'b0;
      r_tms_smp   <= 1'b0;
      r_tdi_smp   <= 1'b0;
      r_tck_level <= 1'b0;
    end else begin
      r_tck_rise <= w_accept_rise;
      r_tck_fall <= w_accept_fall;
      if (w_capture) begin
        r_cand_tms <= w_tms_s;
        r_cand_tdi <= w_tdi_s;
      end
      if (w_accept_rise) begin
        r_tms_smp   <= r_cand_tms;
        r_tdi_smp   <= r_cand_tdi;
        r_tck_level <= 1'b1;
      end else if (w_accept_fall) begin
        r_tck_level <= 1'b0;
      end
    end
  end

  // Saturating count of pulses the filter rejected.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != c_glitch_max)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Forced TAP reset detection
  // --------------------------------------------------------------------------
  // Count consecutive TMS-high rises; pulse only on reaching the threshold,
  // so a longer run of ones does not re-trigger while saturated.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rcnt      <= '0;
      r_tap_reset <= 1'b0;
    end else begin
      r_tap_reset <= 1'b0;
      if (w_accept_rise) begin
        if (r_cand_tms) begin
          if (r_rcnt != c_rcnt_max) begin
            r_rcnt <= r_rcnt + 1'b1;
          end
          if (r_rcnt == c_rcnt_arm) begin
            r_tap_reset <= 1'b1;
          end
        end else begin
          r_rcnt <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // TCK inactivity detection
  // --------------------------------------------------------------------------
  // The counter restarts together with each strobe, so it equals the number
  // of cycles elapsed since the last accepted edge.
  always_comb begin
    w_idle_cnt_next = r_idle_cnt;
    if (w_accept_any) begin
      w_idle_cnt_next = '0;
    end else if (r_idle_cnt != c_idle_max) begin
      w_idle_cnt_next = r_idle_cnt + 1'b1;
    end
  end

  // The idle flag is left untouched on the accepting cycle, so it stays up
  // alongside the waking strobe and drops one cycle later.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idle_cnt <= '0;
      r_tck_idle <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_cnt_next;
      if (!w_accept_any) begin
        r_tck_idle <= (w_idle_cnt_next == c_idle_max);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign pins.tck_rise   = r_tck_rise;
  assign pins.tck_fall   = r_tck_fall;
  assign pins.tms_smp    = r_tms_smp;
  assign pins.tdi_smp    = r_tdi_smp;
  assign pins.tck_level  = r_tck_level;
  assign pins.tap_reset  = r_tap_reset;
  assign pins.tck_idle   = r_tck_idle;
  assign pins.glitch_cnt = r_glitch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jtag_pin_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_pin_frontend
//  Description : Self-checking bench for jtag_pin_frontend. Stimulus pushes
//                expected strobes into a queue; a negedge monitor pops and
//                compares whenever the DUT presents a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_pin_frontend;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int IDLE = 100;
  localparam int RSTN = 5;
  localparam int LAT  = SYNC + FILT;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  jtag_pin_frontend_if pins ();

  jtag_pin_frontend #(
    .SYNC_STAGES     (SYNC),
    .FILTER_LEN      (FILT),
    .IDLE_TIMEOUT    (IDLE),
    .RESET_TMS_COUNT (RSTN)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pins      (pins)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_rise;
    int cyc;
    bit tms;
    bit tdi;
    bit tap_rst;
  } exp_t;

  exp_t exp_q[$];
  bit   tms_hist[$];
  int   glitch_model = 0;
  bit   last_tms = 1'b0;
  bit   last_tdi = 1'b0;
  int   last_exp_cyc = 0;
  int   tap_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Number of consecutive TMS=1 rises ending with the most recent one.
  function automatic int trailing_ones();
    int n = 0;
    int i = tms_hist.size() - 1;
    while (i >= 0 && tms_hist[i]) begin
      n++;
      i--;
    end
    return n;
  endfunction

  // Called at 1 time unit after a posedge; cyc then counts edges so far.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_neg(input int target);
    int guard = 0;
    do begin
      @(negedge sys_clk);
      guard++;
    end while (cyc < target && guard < 100000);
  endtask

  // Drive a clean TCK level and record the strobe it must produce.
  task automatic tck_edge(input logic v);
    exp_t e;
    if (v != pins.jtag_clk) begin
      e.is_rise = v;
      e.cyc     = cyc + LAT;
      e.tms     = pins.jtag_tms;
      e.tdi     = pins.jtag_tdi;
      e.tap_rst = 1'b0;
      if (v) begin
        tms_hist.push_back(pins.jtag_tms);
        e.tap_rst = (trailing_ones() == RSTN);
      end
      exp_q.push_back(e);
      last_exp_cyc = e.cyc;
    end
    pins.jtag_clk = v;
  endtask

  task automatic rise_glitch();
    pins.jtag_clk = 1'b1;
    wait_cyc(2);
    pins.jtag_clk = 1'b0;
    wait_cyc(5);
    if (glitch_model < 255) glitch_model++;
  endtask

  task automatic fall_glitch();
    pins.jtag_clk = 1'b0;
    wait_cyc(2);
    pins.jtag_clk = 1'b1;
    wait_cyc(5);
    if (glitch_model < 255) glitch_model++;
  endtask

  function automatic int all_outputs();
    return int'({pins.tck_rise, pins.tck_fall, pins.tms_smp, pins.tdi_smp,
                 pins.tck_level, pins.tap_reset, pins.tck_idle, pins.glitch_cnt});
  endfunction

  // Monitor: compares every strobe against the scoreboard queue.
  always @(negedge sys_clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missing_strobe_expected_cycle", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (pins.tap_reset) tap_seen++;
    if (pins.tck_rise || pins.tck_fall || pins.tap_reset) begin
      chk("rise_fall_exclusive", int'(pins.tck_rise & pins.tck_fall), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", int'({pins.tck_rise, pins.tck_fall, pins.tap_reset}), 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_is_rise", int'(pins.tck_rise), int'(e.is_rise));
        chk("strobe_is_fall", int'(pins.tck_fall), int'(!e.is_rise));
        chk("tck_level", int'(pins.tck_level), int'(e.is_rise));
        chk("tap_reset", int'(pins.tap_reset), int'(e.tap_rst));
        if (e.is_rise) begin
          last_tms = e.tms;
          last_tdi = e.tdi;
        end
        chk("tms_smp", int'(pins.tms_smp), int'(last_tms));
        chk("tdi_smp", int'(pins.tdi_smp), int'(last_tdi));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tap_before;
    int s_last;
    int s_wake;

    pins.jtag_clk = 1'b0;
    pins.jtag_tms = 1'b0;
    pins.jtag_tdi = 1'b0;
    sys_rst_n     = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outputs", all_outputs(), 0);
    sys_rst_n = 1'b1;
    wait_cyc(2);

    // First accepted rise: TMS=1, TDI=0 set up well ahead.
    pins.jtag_tms = 1'b1;
    pins.jtag_tdi = 1'b0;
    wait_cyc(10);
    tck_edge(1'b1);
    wait_cyc(8);
    tck_edge(1'b0);
    wait_cyc(8);

    // A single short high pulse is rejected and counted.
    chk("glitch_cnt_before", int'(pins.glitch_cnt), glitch_model);
    rise_glitch();
    chk("glitch_cnt_single", int'(pins.glitch_cnt), glitch_model);

    // Clean 50/50 TCK, TMS=0, TDI changing within each period.
    pins.jtag_tms = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 12; i++) begin
      tck_edge(1'b1);
      wait_cyc(4);
      pins.jtag_tdi = 1'($urandom_range(0, 1));
      wait_cyc(4);
      tck_edge(1'b0);
      pins.jtag_tdi = ~pins.jtag_tdi;
      wait_cyc(8);
    end

    // Six TMS=1 rises, one TMS=0, then five TMS=1.
    tap_before    = tap_seen;
    pins.jtag_tms = 1'b1;
    wait_cyc(6);
    for (int i = 0; i < 12; i++) begin
      tck_edge(1'b1);
      wait_cyc(8);
      tck_edge(1'b0);
      pins.jtag_tms = (i == 5) ? 1'b0 : 1'b1;
      wait_cyc(8);
    end
    wait_cyc(2);
    chk("tap_reset_count", tap_seen - tap_before, 2);

    // Randomized periods with occasional rejected low pulses while high.
    for (int i = 0; i < 40; i++) begin
      tck_edge(1'b1);
      wait_cyc(3);
      if ($urandom_range(0, 1) != 0) pins.jtag_tdi = 1'($urandom_range(0, 1));
      wait_cyc($urandom_range(4, 8));
      if ($urandom_range(0, 3) == 0) fall_glitch();
      tck_edge(1'b0);
      pins.jtag_tms = ($urandom_range(0, 3) != 0);
      pins.jtag_tdi = 1'($urandom_range(0, 1));
      wait_cyc($urandom_range(6, 10));
    end
    chk("glitch_cnt_random", int'(pins.glitch_cnt), glitch_model);

    // Inactivity flag timing.
    s_last = last_exp_cyc;
    wait_neg(s_last + IDLE - 1);
    chk("idle_wait_cycle_a", cyc, s_last + IDLE - 1);
    chk("tck_idle_before_timeout", int'(pins.tck_idle), 0);
    wait_neg(s_last + IDLE);
    chk("tck_idle_at_timeout", int'(pins.tck_idle), 1);
    wait_neg(s_last + IDLE + 40);
    chk("tck_idle_held", int'(pins.tck_idle), 1);
    @(posedge sys_clk);
    #1;
    tck_edge(1'b1);
    s_wake = last_exp_cyc;
    wait_neg(s_wake);
    chk("idle_wait_cycle_b", cyc, s_wake);
    chk("tck_idle_with_wake_strobe", int'(pins.tck_idle), 1);
    wait_neg(s_wake + 1);
    chk("tck_idle_after_wake", int'(pins.tck_idle), 0);
    @(posedge sys_clk);
    #1;
    wait_cyc(6);
    tck_edge(1'b0);
    wait_cyc(8);

    // Rejected-pulse counter saturates.
    for (int i = 0; i < 300; i++) rise_glitch();
    chk("glitch_cnt_saturated", int'(pins.glitch_cnt), glitch_model);
    chk("glitch_cnt_is_255", int'(pins.glitch_cnt), 255);

    // Asynchronous reset while a rise is pending.
    pins.jtag_clk = 1'b1;
    wait_cyc(4);
    sys_rst_n     = 1'b0;
    pins.jtag_clk = 1'b0;
    #1;
    chk("reset_mid_filter_outputs", all_outputs(), 0);
    glitch_model = 0;
    tms_hist.delete();
    last_tms = 1'b0;
    last_tdi = 1'b0;
    wait_cyc(3);
    sys_rst_n = 1'b1;
    wait_cyc(20);
    chk("post_reset_glitch_cnt", int'(pins.glitch_cnt), glitch_model);
    chk("post_reset_level", int'(pins.tck_level), 0);

    // Recovery after reset.
    pins.jtag_tms = 1'b1;
    pins.jtag_tdi = 1'b1;
    wait_cyc(6);
    tck_edge(1'b1);
    wait_cyc(8);
    tck_edge(1'b0);
    wait_cyc(12);

    chk("expect_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtag_pin_frontend.md
Name: jtag_pin_frontend

Overview:
- Upstream stage of the JTAG TAP tracker.
- Brings the asynchronous jtag_clk/jtag_tms/jtag_tdi pins into the sys_clk domain and glitch-filters TCK.
- Emits single-cycle rise/fall strobes with TMS/TDI captured at the TCK rising edge.
- Also flags the 5×TMS-high forced-reset sequence and TCK inactivity, so the TAP state machine consumes clean one-cycle events instead of running its own sampling counter.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per pin (legal: 2..4).
- FILTER_LEN, 16, sys_clk cycles a synchronized TCK level must hold before an edge is accepted (legal: >=2).
- IDLE_TIMEOUT, 27000000, sys_clk cycles without an accepted TCK edge before tck_idle asserts (1 s at 27 MHz).
- RESET_TMS_COUNT, 5, consecutive TMS-high rising edges that produce tap_reset.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- jtag_clk  in  1  raw TCK pin, asynchronous.
- jtag_tms  in  1  raw TMS pin, asynchronous.
- jtag_tdi  in  1  raw TDI pin, asynchronous.
- tck_rise  out  1  one-cycle strobe, accepted TCK rising edge.
- tck_fall  out  1  one-cycle strobe, accepted TCK falling edge.
- tms_smp  out  1  TMS captured for the last accepted rise; valid with and after tck_rise.
- tdi_smp  out  1  TDI captured for the last accepted rise; valid with and after tck_rise.
- tck_level  out  1  filtered TCK level.
- tap_reset  out  1  one-cycle strobe, RESET_TMS_COUNT-th consecutive rise with TMS=1.
- tck_idle  out  1  high while no edge has been accepted for IDLE_TIMEOUT cycles.
- glitch_cnt  out  8  saturating count of rejected TCK pulses.

Behaviour:
- Reset: all sync flops 0; FSM=LOW; all outputs 0; internal counters 0.
- Synchronizer: each pin passes through SYNC_STAGES flops, giving tck_s/tms_s/tdi_s. No combinational path from pins to outputs.
- Filter FSM states: LOW, RISE_PEND, HIGH, FALL_PEND. Filter counter fcnt has width clog2(FILTER_LEN).
  - LOW: tck_s=1 -> RISE_PEND, fcnt=1, cand_tms<=tms_s, cand_tdi<=tdi_s (capture at first high sample).
  - RISE_PEND:
    - tck_s=0 -> LOW, glitch_cnt+1 (saturate at 255).
    - Else if fcnt==FILTER_LEN-1 -> HIGH: tck_rise=1, tck_level=1, tms_smp<=cand_tms, tdi_smp<=cand_tdi.
    - Else fcnt+1.
  - HIGH: tck_s=0 -> FALL_PEND, fcnt=1.
  - FALL_PEND:
    - tck_s=1 -> HIGH, glitch_cnt+1 (saturate at 255).
    - Else if fcnt==FILTER_LEN-1 -> LOW: tck_fall=1, tck_level=0.
    - Else fcnt+1.
- Latency: tck_rise/tck_fall assert exactly FILTER_LEN cycles after tck_s first shows the new level, i.e. SYNC_STAGES+FILTER_LEN cycles after the pin edge.
- tck_rise and tck_fall are never asserted in the same cycle.
- TCK held high at reset release yields one tck_rise at SYNC_STAGES+FILTER_LEN cycles. This is intended; the downstream TAP tracker begins in TEST_LOGIC_RESET, so it is harmless.
- tms_smp/tdi_smp change only on tck_rise and hold otherwise.
- Reset-sequence counter rcnt (saturating at RESET_TMS_COUNT), updated on each tck_rise:
  - Captured TMS=1 -> rcnt+1.
  - Captured TMS=0 -> rcnt=0.
  - tap_reset pulses in the same cycle as the tck_rise that takes rcnt from RESET_TMS_COUNT-1 to RESET_TMS_COUNT.
  - Further TMS=1 rises while saturated do not re-pulse.
- Idle counter (25 bits):
  - Cleared on any tck_rise/tck_fall.
  - Otherwise increments, saturating at IDLE_TIMEOUT.
  - tck_idle=1 iff counter==IDLE_TIMEOUT.
  - tck_idle deasserts in the cycle after the next accepted edge.
- Asynchronous reset mid-filter: the pending edge is discarded; no strobe is produced for it.

Test Plan:
- FILTER_LEN=4, SYNC_STAGES=2; pin TCK 0->1 with TMS=1, TDI=0 set up 10 cycles earlier -> tck_rise exactly 6 cycles after the pin edge, tms_smp=1, tdi_smp=0, tck_level=1.
- TCK high pulse of 2 sys_clk cycles -> no tck_rise or tck_fall; glitch_cnt 0->1. Repeat 300 pulses -> glitch_cnt=255 (saturated).
- Clean 50/50 TCK with TMS=0 toggling TDI each cycle -> tck_rise/tck_fall alternate one-for-one; tdi_smp matches TDI at each rising edge.
- Six rises with TMS=1, then one with TMS=0, then five with TMS=1 -> tap_reset exactly on the 5th rise and the 12th rise; none on the 6th.
- IDLE_TIMEOUT=100; stop TCK -> tck_idle=1 exactly 100 cycles after the last strobe; next accepted edge -> tck_idle=0 one cycle later.
- Assert sys_rst_n=0 during RISE_PEND -> all outputs 0 immediately; TCK low at release -> no strobe.
